// File: rtl/frame_out_sched_pkg.sv
// Shared constants and types for the NeoPixel cube frame output path.
package neopixel_pkg;

    localparam int unsigned LED_NUM        = 64;
    localparam int unsigned LAYER_NUM      = 8;
    localparam int unsigned PIXEL_W        = 24;
    localparam int unsigned IDX_W          = 6;
    localparam int unsigned ADDR_W         = IDX_W + 1;
    localparam int unsigned WORD_W         = LAYER_NUM * PIXEL_W;
    localparam int unsigned RST_CYCLES_DEF = 14000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_SEND,
        ST_DRAIN,
        ST_LATCH
    } sched_state_t;

endpackage

// File: rtl/frame_out_sched_if.sv
// Bus bundle between the frame scheduler, the layer RAM read port and the
// encoder bank. master = scheduler side, slave = RAM/encoder/writer side.
interface frame_out_sched_if
    import neopixel_pkg::*;
();

    logic                frame_rdy_in;
    logic                ram_rd_en_out;
    logic [ADDR_W-1:0]   ram_rd_addr_out;
    logic [WORD_W-1:0]   ram_rd_data_in;
    logic                enc_valid_out;
    logic [WORD_W-1:0]   enc_data_out;
    logic                enc_ready_in;
    logic                enc_idle_in;
    logic                busy_out;
    logic                frame_done_out;
    logic                bank_sel_out;

    modport master (
        input  frame_rdy_in,
        output ram_rd_en_out,
        output ram_rd_addr_out,
        input  ram_rd_data_in,
        output enc_valid_out,
        output enc_data_out,
        input  enc_ready_in,
        input  enc_idle_in,
        output busy_out,
        output frame_done_out,
        output bank_sel_out
    );

    modport slave (
        output frame_rdy_in,
        input  ram_rd_en_out,
        input  ram_rd_addr_out,
        output ram_rd_data_in,
        input  enc_valid_out,
        input  enc_data_out,
        output enc_ready_in,
        output enc_idle_in,
        input  busy_out,
        input  frame_done_out,
        input  bank_sel_out
    );

endinterface

// File: rtl/frame_out_sched_latch_timer.sv
// Loadable down-counter with a zero flag, used to time the WS2812 latch gap.
module latch_timer #(
    parameter int unsigned CNT_W = 15
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             load_in,
    input  logic [CNT_W-1:0] load_val_in,
    input  logic             dec_in,
    output logic             zero_out
);

    logic [CNT_W-1:0] count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count <= '0;
        end else if (load_in) begin
            count <= load_val_in;
        end else if (dec_in && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_out = (count == '0);

endmodule

// File: rtl/frame_out_sched.sv
// Frame output scheduler: walks LED indices 0..63, reads all layers in
// parallel, hands each pixel word to the encoders over valid/ready, then
// enforces the latch gap. Define FRAME_DBUF_EN for double-buffered RAM banks.
module frame_out_sched
    import neopixel_pkg::*;
#(
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    frame_out_sched_if.master bus
);

    localparam int unsigned      CNT_W      = $clog2(RST_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(RST_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LED_NUM - 1);

    sched_state_t      state;
    logic [IDX_W-1:0]  idx;
    logic              pend;
    logic              rd_bank;
    logic              start_frame;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;

    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              valid_q;
    logic [WORD_W-1:0] data_q;
    logic              busy_q;
    logic              done_q;

`ifdef FRAME_DBUF_EN
    // bank is the writer's bank; the reader uses the other one.
    logic              bank;
    assign rd_bank          = bank;
    assign bus.bank_sel_out = bank;
`else
    assign rd_bank          = 1'b0;
    assign bus.bank_sel_out = 1'b0;
`endif

    // A frame starts from IDLE, or straight out of the final latch cycle.
    always_comb begin
        start_frame = 1'b0;
        case (state)
            ST_IDLE:  start_frame = bus.frame_rdy_in || pend;
            ST_LATCH: start_frame = tmr_zero && (bus.frame_rdy_in || pend);
            default:  start_frame = 1'b0;
        endcase
    end

    // Latch gap timer control.
    always_comb begin
        tmr_load = (state == ST_DRAIN) && bus.enc_idle_in;
        tmr_dec  = (state == ST_LATCH) && !tmr_zero;
    end

    latch_timer #(
        .CNT_W (CNT_W)
    ) u_latch_timer (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .load_in     (tmr_load),
        .load_val_in (LATCH_LOAD),
        .dec_in      (tmr_dec),
        .zero_out    (tmr_zero)
    );

    // Scheduler FSM with registered outputs; frame start overrides the
    // LATCH exit so a back-to-back frame skips IDLE.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= ST_IDLE;
            idx       <= '0;
            pend      <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef FRAME_DBUF_EN
            bank      <= 1'b0;
`endif
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            pend    <= start_frame ? 1'b0
                                   : (pend | (bus.frame_rdy_in && (state != ST_IDLE)));
            case (state)
                ST_IDLE: begin
                end
                ST_READ: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    data_q  <= bus.ram_rd_data_in;
                    valid_q <= 1'b1;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.enc_ready_in) begin
                        valid_q <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end else begin
                            idx       <= idx + IDX_W'(1);
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= {rd_addr_q[ADDR_W-1], idx + IDX_W'(1)};
                            state     <= ST_READ;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.enc_idle_in) begin
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (tmr_zero) begin
                        done_q <= 1'b1;
                        if (!start_frame) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
            if (start_frame) begin
                state     <= ST_READ;
                idx       <= '0;
                rd_en_q   <= 1'b1;
                rd_addr_q <= {rd_bank, {IDX_W{1'b0}}};
                busy_q    <= 1'b1;
`ifdef FRAME_DBUF_EN
                bank      <= ~bank;
`endif
            end
        end
    end

    assign bus.ram_rd_en_out   = rd_en_q;
    assign bus.ram_rd_addr_out = rd_addr_q;
    assign bus.enc_valid_out   = valid_q;
    assign bus.enc_data_out    = data_q;
    assign bus.busy_out        = busy_q;
    assign bus.frame_done_out  = done_q;

endmodule

// File: tb/tb_frame_out_sched.sv
// Bench for frame_out_sched: start-up timing table, plus a frame-level
// reference model checked every cycle under randomized ready/idle stimulus.
module tb_frame_out_sched;
    import neopixel_pkg::*;

    localparam int unsigned TB_RST = 10;
`ifdef FRAME_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_out_sched_if bus();

    frame_out_sched #(
        .RST_CYCLES (TB_RST)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [WORD_W-1:0] act,
                         input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] pix_word(input int bank, input int idx);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int l = 0; l < int'(LAYER_NUM); l++)
            w[l*PIXEL_W +: PIXEL_W] = {8'(bank), 8'(l), 8'(idx)};
        return w;
    endfunction

    // Layer RAM: registered read, data valid the cycle after the strobe.
    logic [WORD_W-1:0] mem [0:2*LED_NUM-1];
    logic [WORD_W-1:0] ram_q = '0;
    always @(posedge clk) if (bus.ram_rd_en_out) ram_q <= mem[bus.ram_rd_addr_out];
    assign bus.ram_rd_data_in = ram_q;

    // Encoder-side stimulus: 0 = low, 1 = high, 2 = random.
    int unsigned ready_mode = 1;
    int unsigned idle_mode = 1;
    logic rnd_ready = 1'b1;
    logic rnd_idle = 1'b1;
    always begin
        @(posedge clk);
        #1;
        rnd_ready = ($urandom_range(0, 2) != 0);
        rnd_idle  = ($urandom_range(0, 3) == 0);
    end
    assign bus.enc_ready_in = (ready_mode == 2) ? rnd_ready : (ready_mode == 1);
    assign bus.enc_idle_in  = (idle_mode == 2) ? rnd_idle : (idle_mode == 1);

    // Reference model: frame-level events predicted one edge ahead.
    int cyc = 0;
    always @(posedge clk) cyc++;

    int m_busy, m_pend, m_pix, m_rbank, m_wbank, m_start, m_last_hs, m_waiting, m_exp_done;
    int done_seen = 0;
    int last_done_cyc = -1;
    logic prev_valid, prev_hs, hs, fr;
    logic [WORD_W-1:0] prev_data;

    task automatic model_reset();
        m_busy = 0; m_pend = 0; m_pix = 0; m_rbank = 0; m_wbank = 0;
        m_start = -100; m_last_hs = -100; m_waiting = 0; m_exp_done = -1;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_data = '0;
    endtask

    task automatic model_start(input int at);
        m_rbank = DBUF ? m_wbank : 0;
        if (DBUF) m_wbank = m_wbank ^ 1;
        m_pix = 0; m_start = at; m_busy = 1; m_pend = 0;
    endtask

    initial model_reset();

    // Per-cycle monitor: check outputs of edge cyc, then predict edge cyc+1.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            check("busy", bus.busy_out, WORD_W'(m_busy));
            check("bank_sel", bus.bank_sel_out, WORD_W'(m_wbank));
            if (bus.ram_rd_en_out)
                check("rd_addr", bus.ram_rd_addr_out, {1'(m_rbank), 6'(m_pix)});
            if (cyc == m_start) check("rd_en_at_start", bus.ram_rd_en_out, 1);
            if (cyc == m_start + 2) check("valid_latency", bus.enc_valid_out, 1);
            if (cyc == m_exp_done) check("done_timing", bus.frame_done_out, 1);
            else if (bus.frame_done_out) check("done_unexpected", bus.frame_done_out, 0);
            if (bus.frame_done_out) begin
                done_seen++;
                last_done_cyc = cyc;
            end
            if (prev_valid && !prev_hs) begin
                check("stall_valid", bus.enc_valid_out, 1);
                check("stall_data", bus.enc_data_out, prev_data);
            end
            hs = bus.enc_valid_out && bus.enc_ready_in;
            if (hs) begin
                check("pixel_data", bus.enc_data_out, pix_word(m_rbank, m_pix));
                m_pix++;
                if (m_pix == int'(LED_NUM)) begin
                    m_waiting = 1;
                    m_last_hs = cyc + 1;
                end
            end
            if (m_waiting != 0 && cyc + 1 > m_last_hs && bus.enc_idle_in) begin
                m_exp_done = cyc + 1 + int'(TB_RST);
                m_waiting = 0;
            end
            fr = bus.frame_rdy_in;
            if (m_exp_done == cyc + 1) begin
                if (m_pend != 0 || fr) model_start(cyc + 1);
                else begin m_busy = 0; m_pend = 0; end
            end else if (fr) begin
                if (m_busy == 0) model_start(cyc + 1);
                else m_pend = 1;
            end
            prev_valid = bus.enc_valid_out;
            prev_hs = hs;
            prev_data = bus.enc_data_out;
        end
    end

    task automatic pulse_rdy();
        bus.frame_rdy_in = 1'b1;
        @(posedge clk); #1;
        bus.frame_rdy_in = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = done_seen;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_seen > start) return;
        end
        checks++; failures++;
        $display("FAIL wait_done timeout actual=no_done required=done");
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.enc_valid_out) return;
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL wait_valid timeout actual=0 required=1");
    endtask

    task automatic wait_pix(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_pix >= n) return;
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL wait_pix timeout actual=%0d required=%0d", m_pix, n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, bus.ram_rd_en_out, 0);
        check({tag, "_rd_addr"}, bus.ram_rd_addr_out, 0);
        check({tag, "_valid"}, bus.enc_valid_out, 0);
        check({tag, "_data"}, bus.enc_data_out, 0);
        check({tag, "_busy"}, bus.busy_out, 0);
        check({tag, "_done"}, bus.frame_done_out, 0);
        check({tag, "_bank_sel"}, bus.bank_sel_out, 0);
    endtask

    typedef struct {
        logic       rdy;
        int         rmode;
        logic       exp_en;
        logic       exp_valid;
        logic [5:0] exp_idx;
    } vec_t;
    vec_t vecs [9];

    int hs_edge;

    initial begin
        vecs[0] = '{1'b1, 1, 1'b1, 1'b0, 6'd0};
        vecs[1] = '{1'b0, 0, 1'b0, 1'b0, 6'd0};
        vecs[2] = '{1'b0, 0, 1'b0, 1'b1, 6'd0};
        vecs[3] = '{1'b0, 0, 1'b0, 1'b1, 6'd0};
        vecs[4] = '{1'b0, 1, 1'b1, 1'b0, 6'd1};
        vecs[5] = '{1'b0, 1, 1'b0, 1'b0, 6'd1};
        vecs[6] = '{1'b0, 1, 1'b0, 1'b1, 6'd1};
        vecs[7] = '{1'b0, 0, 1'b0, 1'b1, 6'd1};
        vecs[8] = '{1'b0, 1, 1'b1, 1'b0, 6'd2};

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < int'(LED_NUM); i++)
                mem[b*LED_NUM + i] = pix_word(b, i);

        bus.frame_rdy_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame 1: start-up and stall timing from the table, then run out.
        for (int i = 0; i < 9; i++) begin
            bus.frame_rdy_in = vecs[i].rdy;
            ready_mode = vecs[i].rmode;
            @(posedge clk); #1;
            check($sformatf("vec%0d_rd_en", i), bus.ram_rd_en_out, vecs[i].exp_en);
            check($sformatf("vec%0d_valid", i), bus.enc_valid_out, vecs[i].exp_valid);
            check($sformatf("vec%0d_idx", i), bus.ram_rd_addr_out[5:0], vecs[i].exp_idx);
        end
        bus.frame_rdy_in = 1'b0;
        ready_mode = 1;
        wait_done(1000);

        // Frame 2: three requests while busy collapse into one extra frame.
        repeat (3) @(posedge clk);
        #1;
        ready_mode = 2;
        pulse_rdy();
        for (int p = 0; p < 3; p++) begin
            repeat (5) @(posedge clk);
            #1;
            wait_valid(50);
            pulse_rdy();
        end
        wait_done(2000);
        wait_done(2000);
        repeat (15) @(posedge clk);
        #1;
        check("collapsed_busy_after", bus.busy_out, 0);

        // Frame 4: encoders stay busy 100 cycles after the last handshake.
        idle_mode = 0;
        ready_mode = 1;
        pulse_rdy();
        for (int i = 0; i < 1000 && m_waiting == 0; i++) begin
            @(posedge clk); #1;
        end
        hs_edge = m_last_hs;
        repeat (100) @(posedge clk);
        #1;
        idle_mode = 1;
        wait_done(300);
        check("idle_delay_done_cycle", WORD_W'(last_done_cyc - hs_edge),
              WORD_W'(101 + TB_RST));

        // Frame 5: random ready and random encoder idle.
        ready_mode = 2;
        idle_mode = 2;
        pulse_rdy();
        wait_done(3000);
        idle_mode = 1;

        // Frame 6: reset mid-frame aborts with no done pulse.
        repeat (2) @(posedge clk);
        #1;
        pulse_rdy();
        wait_pix(30, 1000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_busy", bus.busy_out, 0);

        // Frame 7 after reset restarts at index 0.
        ready_mode = 1;
        pulse_rdy();
        check("restart_idx", bus.ram_rd_addr_out[5:0], 0);
        wait_done(1000);
        check("total_done_pulses", WORD_W'(done_seen), 6);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
